// File: rtl/ifu_imem_if.sv
// Instruction memory request/grant/response port between the fetch controller and imem.
interface ifu_imem_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Fetch controller: sequences one imem request per instruction, buffers responses
// across decode stalls, drops responses after a flush, and owns the IF/ID register.
module ifu_fetch_ctrl (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc,
    output logic              pc_stall,
    input  logic              stall_D,
    input  logic              flush_D,
    ifu_imem_if.master        imem,
    output logic [31:0]       instr_D,
    output logic [31:0]       pc_D,
    output logic              valid_D,
    output logic              exc_adel_D
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

    state_t      state, nxt;
    logic [31:0] pc_hold, bf_instr, bf_pc;
    logic        bf_exc;
    logic        pc_legal;

    logic        deliver, bf_load, hold_load;
    logic [31:0] dl_instr, dl_pc, bf_instr_n, bf_pc_n;
    logic        dl_exc, bf_exc_n;

    assign pc_legal = (pc[1:0] == 2'b00) && (pc >= 32'h0000_3000) && (pc <= 32'h0000_6FFC);

    always_comb begin
        nxt        = state;
        pc_stall   = 1'b1;
        imem.req   = 1'b0;
        imem.addr  = 32'h0;
        deliver    = 1'b0;
        dl_instr   = 32'h0;
        dl_pc      = 32'h0;
        dl_exc     = 1'b0;
        bf_load    = 1'b0;
        bf_instr_n = 32'h0;
        bf_pc_n    = 32'h0;
        bf_exc_n   = 1'b0;
        hold_load  = 1'b0;
        case (state)
            IDLE: nxt = REQ;
            REQ: begin
                if (pc_legal) begin
                    imem.req  = 1'b1;
                    imem.addr = pc;
                    if (flush_D) begin
                        pc_stall = 1'b0;
                        if (imem.gnt) nxt = DROP;
                    end else if (imem.gnt) begin
                        hold_load = 1'b1;
                        nxt       = WAIT;
                    end
                end else if (flush_D) begin
                    pc_stall = 1'b0;
                end else if (stall_D) begin
                    // illegal pc behaves like a returned word: park it until decode frees up
                    bf_load    = 1'b1;
                    bf_pc_n    = pc;
                    bf_exc_n   = 1'b1;
                    nxt        = HOLD;
                end else begin
                    deliver  = 1'b1;
                    dl_pc    = pc;
                    dl_exc   = 1'b1;
                    pc_stall = 1'b0;
                end
            end
            WAIT: begin
                if (flush_D) begin
                    pc_stall = 1'b0;
                    nxt      = imem.rvalid ? REQ : DROP;
                end else if (imem.rvalid) begin
                    if (stall_D) begin
                        bf_load    = 1'b1;
                        bf_instr_n = imem.rdata;
                        bf_pc_n    = pc_hold;
                        nxt        = HOLD;
                    end else begin
                        deliver  = 1'b1;
                        dl_instr = imem.rdata;
                        dl_pc    = pc_hold;
                        pc_stall = 1'b0;
                        nxt      = REQ;
                    end
                end
            end
            HOLD: begin
                if (flush_D) begin
                    pc_stall = 1'b0;
                    nxt      = REQ;
                end else if (!stall_D) begin
                    deliver  = 1'b1;
                    dl_instr = bf_instr;
                    dl_pc    = bf_pc;
                    dl_exc   = bf_exc;
                    pc_stall = 1'b0;
                    nxt      = REQ;
                end
            end
            DROP: begin
                // a response consumed here is stale even if another flush arrives with it
                if (flush_D) pc_stall = 1'b0;
                if (imem.rvalid) nxt = REQ;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_hold  <= 32'h0;
            bf_instr <= 32'h0;
            bf_pc    <= 32'h0;
            bf_exc   <= 1'b0;
        end else begin
            if (hold_load) pc_hold <= pc;
            if (bf_load) begin
                bf_instr <= bf_instr_n;
                bf_pc    <= bf_pc_n;
                bf_exc   <= bf_exc_n;
            end
        end
    end

    // IF/ID register: flush beats stall beats delivery; bubbles keep the last pc_D
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_D    <= 32'h0;
            pc_D       <= 32'h0;
            valid_D    <= 1'b0;
            exc_adel_D <= 1'b0;
        end else if (flush_D || (!stall_D && !deliver)) begin
            instr_D    <= 32'h0;
            valid_D    <= 1'b0;
            exc_adel_D <= 1'b0;
        end else if (!stall_D) begin
            instr_D    <= dl_instr;
            pc_D       <= dl_pc;
            valid_D    <= 1'b1;
            exc_adel_D <= dl_exc;
        end
    end
endmodule
